// File: rtl/regfile_writeback_pkg.sv
// Shared processor constants and the write-back entry type.
// Contents:
//   REG_IDX_W  - register index width
//   DATA_W     - register data width
//   NUM_REGS   - architectural register count
//   wb_entry_t - one pending write (destination index plus data)
//   is_x0()    - true when an index names the hard-wired zero register
package regfile_writeback_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  function automatic logic is_x0(input logic [REG_IDX_W-1:0] rd);
    return (rd == {REG_IDX_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that buffers load results ahead of write-back.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data - enqueue request and entry (ignored while full)
//   pop           - dequeue request (ignored while empty)
//   head_data     - oldest entry, valid while not empty
//   count         - occupancy, 0..DEPTH
//   full, empty   - occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == {CNT_W{1'b0}});
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Entry storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter with load buffer and busy scoreboard.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data     - ALU result offer, accepted with alu_ready
//   ld_valid/ld_rd/ld_data        - load result offer, enqueued with ld_ready
//   issue_en/issue_rd             - issued instruction that will write issue_rd
//   rf_we/rf_rd/rf_wdata          - registered register-file write port
//   busy                          - scoreboard, bit n set while xn has a pending write
//   ld_count                      - load FIFO occupancy
// One result is written per cycle: a full load FIFO drains first so loads
// cannot starve, otherwise the ALU wins, otherwise a buffered load drains.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [REG_IDX_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  input  logic                    ld_valid,
  input  logic [REG_IDX_W-1:0]    ld_rd,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_ready,
  input  logic                    issue_en,
  input  logic [REG_IDX_W-1:0]    issue_rd,
  output logic                    rf_we,
  output logic [REG_IDX_W-1:0]    rf_rd,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]     busy,
  output logic [$clog2(LD_DEPTH):0] ld_count
);

  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  wb_entry_t             ld_entry;
  wb_entry_t             head;
  wb_entry_t             sel;
  logic                  sel_valid;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  write_en;
  logic                  set_en;
  logic [NUM_REGS-1:0]   clr_mask;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   busy_next;

  assign ld_entry  = '{rd: ld_rd, data: ld_data};
  assign alu_ready = !fifo_full;
  assign ld_ready  = !fifo_full;

  wb_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_ld_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ld_valid && ld_ready),
    .push_data (ld_entry),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (ld_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Source arbitration: full FIFO, then ALU, then non-empty FIFO.
  always_comb begin
    sel_valid = 1'b0;
    fifo_pop  = 1'b0;
    sel       = head;
    if (fifo_full) begin
      sel_valid = 1'b1;
      fifo_pop  = 1'b1;
      sel       = head;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel       = '{rd: alu_rd, data: alu_data};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      fifo_pop  = 1'b1;
      sel       = head;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Results for x0 are consumed but never reach the register file.
  assign write_en = sel_valid && !is_x0(sel.rd);
  assign set_en   = issue_en && !is_x0(issue_rd);

  // Scoreboard update: a same-cycle issue overrides the completing write; x0 stays clear.
  always_comb begin
    clr_mask  = write_en ? (ONE_HOT0 << sel.rd) : {NUM_REGS{1'b0}};
    set_mask  = set_en ? (ONE_HOT0 << issue_rd) : {NUM_REGS{1'b0}};
    busy_next = ((busy & ~clr_mask) | set_mask) & ~ONE_HOT0;
  end

  // Registered write port and scoreboard; index/data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= {REG_IDX_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
      busy     <= {NUM_REGS{1'b0}};
    end else begin
      rf_we <= write_en;
      if (write_en) begin
        rf_rd    <= sel.rd;
        rf_wdata <= sel.data;
      end
      busy <= busy_next;
    end
  end

endmodule
